// File: rtl/t_result_collect.sv
// rtl/t_result_collect.sv - sequenced pass/fail collector for regression subtest channels
//
// Purpose: tracks per-channel completion and verdicts during a run, enforces a
// cycle timeout, optionally aborts on the first failure, and exports a
// registered overall verdict plus diagnostic masks.
//
// Ports:
//   clk          single clock, all state on posedge
//   reset        synchronous active-high reset, overrides every other input
//   start        pulse; begins or restarts a run (from any non-reset state)
//   chan_enable  channels taking part, sampled only on the start cycle
//   chan_done    per-channel completion strobe
//   chan_passed  per-channel verdict, qualified by chan_done
//   chan_error   per-channel error flag, honoured on any RUN cycle
//   passed       overall pass (registered)
//   done         run finished, PASS or FAIL (registered)
//   timed_out    run failed because the cycle budget ran out
//   done_mask    channels that have reported (disabled channels read as done)
//   fail_mask    channels that failed
//   cycle_count  cycles spent in RUN, frozen once the run finishes
module t_result_collect #(
    parameter int NCHAN         = 21,
    parameter int TIMEOUT       = 1000,
    parameter int CNT_W         = 16,
    parameter int ABORT_ON_FAIL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NCHAN-1:0] chan_enable,
    input  logic [NCHAN-1:0] chan_done,
    input  logic [NCHAN-1:0] chan_passed,
    input  logic [NCHAN-1:0] chan_error,
    output logic             passed,
    output logic             done,
    output logic             timed_out,
    output logic [NCHAN-1:0] done_mask,
    output logic [NCHAN-1:0] fail_mask,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);
    localparam logic             ABORT_EN   = (ABORT_ON_FAIL != 0);

    state_t           state;
    logic [NCHAN-1:0] en_q;

    // Next-state masks for the RUN state. Only the first report of an enabled
    // channel counts; errors on enabled channels fail them even after done.
    logic [NCHAN-1:0] new_report;
    logic [NCHAN-1:0] done_nxt;
    logic [NCHAN-1:0] fail_nxt;
    logic             all_done_nxt;
    logic             any_fail_nxt;

    always_comb begin
        new_report   = chan_done & en_q & ~done_mask;
        done_nxt     = done_mask | new_report;
        fail_nxt     = fail_mask | (new_report & ~chan_passed) | (chan_error & en_q);
        all_done_nxt = &done_nxt;
        any_fail_nxt = |fail_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            en_q        <= '0;
            passed      <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            done_mask   <= '0;
            fail_mask   <= '0;
            cycle_count <= '0;
        end else if (start) begin
            // Start has the same effect from every state: fresh run.
            state       <= ST_RUN;
            en_q        <= chan_enable;
            done_mask   <= ~chan_enable;
            fail_mask   <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            passed      <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    done_mask   <= done_nxt;
                    fail_mask   <= fail_nxt;
                    // TIMEOUT < 2^CNT_W and RUN always exits on the
                    // TIMEOUT-1 cycle, so this cannot wrap.
                    cycle_count <= cycle_count + 1'b1;
                    if (ABORT_EN && any_fail_nxt) begin
                        state <= ST_FAIL;
                        done  <= 1'b1;
                    end else if (all_done_nxt) begin
                        // Completion on the timeout cycle takes priority.
                        state  <= any_fail_nxt ? ST_FAIL : ST_PASS;
                        passed <= ~any_fail_nxt;
                        done   <= 1'b1;
                    end else if (cycle_count == LAST_CYCLE) begin
                        state     <= ST_FAIL;
                        timed_out <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    // IDLE waits for start; PASS/FAIL hold everything frozen.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_result_collect.sv
// tb/tb_t_result_collect.sv - directed self-checking bench for t_result_collect
module tb_t_result_collect;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] chan_enable;
    logic [3:0] chan_done;
    logic [3:0] chan_passed;
    logic [3:0] chan_error;

    logic        a_passed, a_done, a_timed_out;
    logic [3:0]  a_done_mask, a_fail_mask;
    logic [15:0] a_count;
    logic        n_passed, n_done, n_timed_out;
    logic [3:0]  n_done_mask, n_fail_mask;
    logic [15:0] n_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    t_result_collect #(.NCHAN(4), .TIMEOUT(20), .CNT_W(16), .ABORT_ON_FAIL(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .chan_enable(chan_enable),
        .chan_done(chan_done), .chan_passed(chan_passed), .chan_error(chan_error),
        .passed(a_passed), .done(a_done), .timed_out(a_timed_out),
        .done_mask(a_done_mask), .fail_mask(a_fail_mask), .cycle_count(a_count)
    );

    t_result_collect #(.NCHAN(4), .TIMEOUT(20), .CNT_W(16), .ABORT_ON_FAIL(0)) dut_n (
        .clk(clk), .reset(reset), .start(start), .chan_enable(chan_enable),
        .chan_done(chan_done), .chan_passed(chan_passed), .chan_error(chan_error),
        .passed(n_passed), .done(n_done), .timed_out(n_timed_out),
        .done_mask(n_done_mask), .fail_mask(n_fail_mask), .cycle_count(n_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic step(input logic [3:0] d, input logic [3:0] p, input logic [3:0] e);
        chan_done = d; chan_passed = p; chan_error = e;
        cyc();
        chan_done = '0; chan_passed = '0; chan_error = '0;
    endtask

    task automatic start_run(input logic [3:0] en);
        start = 1'b1; chan_enable = en;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; chan_enable = 4'hF;
        chan_done = '0; chan_passed = '0; chan_error = '0;
        idle(2);
        reset = 1'b0; start = 1'b0;
        n_cmp++; if ({a_passed, a_done, a_timed_out} !== 3'b000) begin n_bad++; $display("FAIL reset_flags act=%b exp=000", {a_passed, a_done, a_timed_out}); end
        n_cmp++; if ({a_done_mask, a_fail_mask} !== 8'h00) begin n_bad++; $display("FAIL reset_masks act=%h exp=00", {a_done_mask, a_fail_mask}); end
        n_cmp++; if (a_count !== 16'd0) begin n_bad++; $display("FAIL reset_count act=%0d exp=0", a_count); end
    endtask

    task automatic test_all_pass();
        start_run(4'hF);
        idle(2); step(4'h1, 4'h1, 4'h0);
        idle(1); step(4'h2, 4'h2, 4'h0);
        idle(1); step(4'h4, 4'h4, 4'h0);
        idle(1);
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL t1_not_done_yet act=%b exp=0", a_done); end
        step(4'h8, 4'h8, 4'h0);
        n_cmp++; if ({a_done, a_passed} !== 2'b11) begin n_bad++; $display("FAIL t1_a_verdict act=%b exp=11", {a_done, a_passed}); end
        n_cmp++; if ({n_done, n_passed} !== 2'b11) begin n_bad++; $display("FAIL t1_n_verdict act=%b exp=11", {n_done, n_passed}); end
        n_cmp++; if (a_done_mask !== 4'hF) begin n_bad++; $display("FAIL t1_done_mask act=%h exp=f", a_done_mask); end
        n_cmp++; if (a_count !== 16'd9) begin n_bad++; $display("FAIL t1_count act=%0d exp=9", a_count); end
        step(4'hF, 4'h0, 4'hF);
        idle(2);
        n_cmp++; if (a_count !== 16'd9) begin n_bad++; $display("FAIL t1_count_frozen act=%0d exp=9", a_count); end
        n_cmp++; if ({a_fail_mask, a_passed} !== 5'b0000_1) begin n_bad++; $display("FAIL t1_inputs_ignored act=%b exp=00001", {a_fail_mask, a_passed}); end
    endtask

    task automatic test_abort();
        start_run(4'hF);
        idle(3);
        step(4'h4, 4'h0, 4'h0);
        n_cmp++; if ({a_done, a_passed} !== 2'b10) begin n_bad++; $display("FAIL t2_a_verdict act=%b exp=10", {a_done, a_passed}); end
        n_cmp++; if ({a_fail_mask, a_done_mask} !== 8'h44) begin n_bad++; $display("FAIL t2_masks act=%h exp=44", {a_fail_mask, a_done_mask}); end
        n_cmp++; if (a_count !== 16'd4) begin n_bad++; $display("FAIL t2_count act=%0d exp=4", a_count); end
        n_cmp++; if (n_done !== 1'b0) begin n_bad++; $display("FAIL t2_noabort_running act=%b exp=0", n_done); end
    endtask

    task automatic test_disabled_ignored();
        start_run(4'h3);
        n_cmp++; if (a_done_mask !== 4'hC) begin n_bad++; $display("FAIL t3_initial_done_mask act=%h exp=c", a_done_mask); end
        idle(1);
        step(4'hB, 4'h3, 4'h8);
        n_cmp++; if ({a_done, a_passed} !== 2'b11) begin n_bad++; $display("FAIL t3_verdict act=%b exp=11", {a_done, a_passed}); end
        n_cmp++; if ({a_fail_mask, n_fail_mask} !== 8'h00) begin n_bad++; $display("FAIL t3_fail_mask act=%h exp=00", {a_fail_mask, n_fail_mask}); end
    endtask

    task automatic test_timeout();
        start_run(4'hF);
        step(4'h7, 4'h7, 4'h0);
        idle(18);
        n_cmp++; if ({a_count, a_done} !== {16'd19, 1'b0}) begin n_bad++; $display("FAIL t4_pre_timeout act=%0d/%b exp=19/0", a_count, a_done); end
        cyc();
        n_cmp++; if ({a_done, a_passed, a_timed_out} !== 3'b101) begin n_bad++; $display("FAIL t4_timeout_flags act=%b exp=101", {a_done, a_passed, a_timed_out}); end
        n_cmp++; if ({n_done, n_timed_out} !== 2'b11) begin n_bad++; $display("FAIL t4_n_timeout act=%b exp=11", {n_done, n_timed_out}); end
        n_cmp++; if (a_done_mask !== 4'h7) begin n_bad++; $display("FAIL t4_done_mask act=%h exp=7", a_done_mask); end
        n_cmp++; if (a_count !== 16'd20) begin n_bad++; $display("FAIL t4_count act=%0d exp=20", a_count); end
        // Completion on the final cycle beats the timeout.
        start_run(4'hF);
        n_cmp++; if ({a_done, a_timed_out, a_count} !== {2'b00, 16'd0}) begin n_bad++; $display("FAIL t4_restart_clear act=%b/%0d exp=00/0", {a_done, a_timed_out}, a_count); end
        step(4'h7, 4'h7, 4'h0);
        idle(18);
        step(4'h8, 4'h8, 4'h0);
        n_cmp++; if ({a_done, a_passed, a_timed_out} !== 3'b110) begin n_bad++; $display("FAIL t4_late_pass act=%b exp=110", {a_done, a_passed, a_timed_out}); end
        n_cmp++; if (a_done_mask !== 4'hF) begin n_bad++; $display("FAIL t4_late_done_mask act=%h exp=f", a_done_mask); end
    endtask

    task automatic test_no_abort_sticky();
        start_run(4'hF);
        step(4'h2, 4'h2, 4'h0);
        step(4'h2, 4'h0, 4'h0);
        n_cmp++; if (n_fail_mask !== 4'h0) begin n_bad++; $display("FAIL t5_redo_ignored act=%h exp=0", n_fail_mask); end
        step(4'h0, 4'h0, 4'h1);
        n_cmp++; if ({n_fail_mask, n_done} !== 5'b0001_0) begin n_bad++; $display("FAIL t5_error_marks act=%b exp=00010", {n_fail_mask, n_done}); end
        n_cmp++; if ({a_done, a_passed} !== 2'b10) begin n_bad++; $display("FAIL t5_a_aborts act=%b exp=10", {a_done, a_passed}); end
        step(4'h1, 4'h1, 4'h0);
        step(4'h4, 4'h4, 4'h0);
        n_cmp++; if (n_done !== 1'b0) begin n_bad++; $display("FAIL t5_waits act=%b exp=0", n_done); end
        step(4'h8, 4'h8, 4'h0);
        n_cmp++; if ({n_done, n_passed} !== 2'b10) begin n_bad++; $display("FAIL t5_verdict act=%b exp=10", {n_done, n_passed}); end
        n_cmp++; if ({n_fail_mask, n_done_mask} !== 8'h1F) begin n_bad++; $display("FAIL t5_masks act=%h exp=1f", {n_fail_mask, n_done_mask}); end
    endtask

    task automatic test_reset_and_restart();
        start_run(4'hF);
        step(4'h1, 4'h0, 4'h0);
        idle(4);
        reset = 1'b1; start = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0;
        n_cmp++; if ({n_done, n_passed, n_timed_out, n_done_mask, n_fail_mask, n_count} !== 27'd0) begin n_bad++; $display("FAIL t6_mid_reset act=%b/%h/%h/%0d exp=000/0/0/0", {n_done, n_passed, n_timed_out}, n_done_mask, n_fail_mask, n_count); end
        step(4'hF, 4'hF, 4'hF);
        n_cmp++; if ({n_done, n_done_mask, n_count} !== 21'd0) begin n_bad++; $display("FAIL t6_idle_holds act=%b/%h/%0d exp=0/0/0", n_done, n_done_mask, n_count); end
        // Empty enable: one RUN cycle then PASS.
        start_run(4'h0);
        cyc();
        n_cmp++; if ({n_done, n_passed, n_count} !== {2'b11, 16'd1}) begin n_bad++; $display("FAIL t6_empty_run act=%b/%0d exp=11/1", {n_done, n_passed}, n_count); end
        start_run(4'hF);
        n_cmp++; if ({n_done, n_passed, n_done_mask, n_fail_mask} !== 10'd0) begin n_bad++; $display("FAIL t6_restart_clear act=%b/%h/%h exp=00/0/0", {n_done, n_passed}, n_done_mask, n_fail_mask); end
        step(4'h3, 4'h3, 4'h0);
        // Restart while running: masks and counter clear, enable resampled.
        start_run(4'h6);
        n_cmp++; if ({n_done_mask, n_count} !== {4'h9, 16'd0}) begin n_bad++; $display("FAIL t6_run_restart act=%h/%0d exp=9/0", n_done_mask, n_count); end
        step(4'h6, 4'h6, 4'h0);
        n_cmp++; if ({n_done, n_passed, n_count} !== {2'b11, 16'd1}) begin n_bad++; $display("FAIL t6_rerun_pass act=%b/%0d exp=11/1", {n_done, n_passed}, n_count); end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_abort();
        test_disabled_ignored();
        test_timeout();
        test_no_abort_sticky();
        test_reset_and_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
